// File: rtl/icache_direct.sv
// icache_direct -- direct-mapped, read-only instruction cache.
//
// Sits between instruction fetch and a slow word-wide instruction memory.
// The instruction is returned combinationally on a hit. A miss stalls fetch
// while a 4-word line is refilled through a req/ack handshake.
//
// Ports:
//   i_clk, i_rst_n  clock (rising edge), synchronous active-low reset
//   i_req, i_pc     fetch request and word-aligned byte address
//   o_inst          instruction on a hit, 32'h0 otherwise
//   o_stall         fetch must hold PC and IF/ID this cycle
//   i_flush         invalidate every line
//   o_mem_req       backing-memory read request (held through the refill)
//   o_mem_addr      byte address of the word being refilled
//   i_mem_ack       i_mem_data valid this cycle
//   i_mem_data      backing-memory read data
//   o_miss_cnt      saturating miss counter
module icache_direct #(
   parameter int unsigned INDEX_BITS = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   input  logic [31:0] i_pc,
   output logic [31:0] o_inst,
   output logic        o_stall,
   input  logic        i_flush,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_data,
   output logic [15:0] o_miss_cnt
);

   localparam int unsigned TAG_BITS = 28 - INDEX_BITS;
   localparam int unsigned LINES    = 1 << INDEX_BITS;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t                        state, state_nxt;
   logic [LINES-1:0]              valid;
   logic [TAG_BITS-1:0]           tag_mem  [LINES];
   // Data words are stored flat, addressed by {index, word offset}.
   logic [31:0]                   data_mem [LINES*4];
   logic [27:0]                   base;           // line address pc[31:4]
   logic [1:0]                    cnt;
   logic                          flush_pending;
   logic [15:0]                   miss_cnt;

   logic [INDEX_BITS-1:0]         idx;
   logic [TAG_BITS-1:0]           tag;
   logic [1:0]                    off;
   logic [INDEX_BITS-1:0]         base_idx;
   logic [TAG_BITS-1:0]           base_tag;
   logic                          hit;
   logic                          miss;
   logic                          last_ack;
   logic                          drop_line;

   assign idx      = i_pc[3+INDEX_BITS:4];
   assign tag      = i_pc[31:4+INDEX_BITS];
   assign off      = i_pc[3:2];
   assign base_idx = base[INDEX_BITS-1:0];
   assign base_tag = base[27:INDEX_BITS];

   assign hit      = (state == IDLE) && i_req && valid[idx] && (tag_mem[idx] == tag);
   assign miss     = (state == IDLE) && i_req && !hit;
   assign last_ack = (state == REFILL) && i_mem_ack && (cnt == 2'd3);
   // A flush arriving on the final ack is honoured as well, so the
   // just-filled line never survives a flush request seen during its refill.
   assign drop_line = flush_pending || i_flush;

   // Next-state and outputs
   always_comb begin
      state_nxt  = state;
      o_inst     = '0;
      o_stall    = 1'b0;
      o_mem_req  = 1'b0;
      o_mem_addr = '0;
      case (state)
         IDLE: begin
            if (hit) begin
               o_inst = data_mem[{idx, off}];
            end
            if (miss) begin
               o_stall   = 1'b1;
               state_nxt = REFILL;
            end
         end
         REFILL: begin
            o_stall    = 1'b1;
            o_mem_req  = 1'b1;
            // base has zero low nibble, so base + 4*cnt is a concatenation.
            o_mem_addr = {base, cnt, 2'b00};
            if (last_ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and control state
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         valid         <= '0;
         base          <= '0;
         cnt           <= '0;
         flush_pending <= 1'b0;
         miss_cnt      <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (i_flush) begin
                  valid <= '0;
               end
               if (miss) begin
                  base          <= i_pc[31:4];
                  cnt           <= '0;
                  flush_pending <= 1'b0;
                  if (miss_cnt != 16'hFFFF) begin
                     miss_cnt <= miss_cnt + 16'd1;
                  end
               end
            end
            REFILL: begin
               if (i_flush) begin
                  flush_pending <= 1'b1;
               end
               if (i_mem_ack) begin
                  cnt <= cnt + 2'd1;
               end
               if (last_ack) begin
                  flush_pending <= 1'b0;
                  if (drop_line) begin
                     valid <= '0;
                  end else begin
                     valid[base_idx] <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Tag and data arrays carry no reset; valid gates every use of them.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && (state == REFILL) && i_mem_ack) begin
         data_mem[{base_idx, cnt}] <= i_mem_data;
         if (cnt == 2'd3) begin
            tag_mem[base_idx] <= base_tag;
         end
      end
   end

   assign o_miss_cnt = miss_cnt;

endmodule
